// File: rtl/mfp_uart_char_receiver_pkg.sv
// Shared definitions for the S-record UART receive path: FSM state encoding and
// bit-period arithmetic, kept here so a future transmitter can reuse them.
package mfp_uart_char_receiver_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StStart     = 3'd1,
        StData      = 3'd2,
        StStop      = 3'd3,
        StBreakWait = 3'd4
    } rx_state_e;

    function automatic int unsigned cycles_per_bit(input int unsigned clock_frequency,
                                                   input int unsigned baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/mfp_sync2.sv
// Two-flop synchronizer for a single asynchronous input; flops reset to RESET_VALUE.
module mfp_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mfp_uart_char_receiver.sv
// 8N1 UART receiver: oversamples rx, frames characters and emits each byte as a
// one-cycle char_data/char_ready pulse for the S-record parser.
module mfp_uart_char_receiver
    import mfp_uart_char_receiver_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
    parameter int unsigned BAUD_RATE       = 115_200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] char_data,
    output logic       char_ready,
    output logic       framing_error,
    output logic       busy
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_BIT - 1);

    generate
        if (CYCLES_PER_BIT < 4) begin : g_bad_ratio
            $error("mfp_uart_char_receiver: CYCLES_PER_BIT must be at least 4");
        end
    endgenerate

    logic             rx_s;
    rx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    mfp_sync2 #(
        .RESET_VALUE(1'b1)
    ) u_rx_sync (
        .clock(clock),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            char_data     <= '0;
            char_ready    <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            char_ready    <= 1'b0;
            framing_error <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state <= StStart;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                StStart: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (!rx_s) begin
                            state <= StData;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: begin
                    if (cnt == CNT_LAST) begin
                        shift   <= {rx_s, shift[7:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= StStop;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StStop: begin
                    // Decided at mid stop bit so IDLE catches a back-to-back start edge.
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            char_data  <= shift;
                            char_ready <= 1'b1;
                            state      <= StIdle;
                            busy       <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= StBreakWait;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StBreakWait: begin
                    if (rx_s) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_uart_char_receiver.sv
// Directed self-checking bench for mfp_uart_char_receiver at 16 clocks per bit.
module tb_mfp_uart_char_receiver;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned BIT_T    = 160;  // 16 clocks of 10 time units

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] char_data;
    logic       char_ready;
    logic       framing_error;
    logic       busy;

    always #5 clock = ~clock;

    mfp_uart_char_receiver #(
        .CLOCK_FREQUENCY(CLK_FREQ),
        .BAUD_RATE      (BAUD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .char_data    (char_data),
        .char_ready   (char_ready),
        .framing_error(framing_error),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         e0_cyc = 0;
    logic [7:0] got_q[$];
    int         ready_cnt = 0;
    int         fe_cnt = 0;
    int         overlap_cnt = 0;
    int         long_cnt = 0;
    int         ready_cyc = 0;
    logic       prev_ready = 1'b0;
    logic       prev_fe = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (char_ready) begin
            got_q.push_back(char_data);
            ready_cnt <= ready_cnt + 1;
            ready_cyc <= cyc;
        end
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (char_ready && framing_error) overlap_cnt <= overlap_cnt + 1;
        if ((char_ready && prev_ready) || (framing_error && prev_fe)) long_cnt <= long_cnt + 1;
        prev_ready <= char_ready;
        prev_fe    <= framing_error;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [31:0] v;
        v = 'x;
        if (got_q.size() > 0) v = {24'h0, got_q.pop_front()};
        check_eq(tag, v, {24'h0, exp});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called one time unit after a rising edge; the next edge is E0.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned bit_t);
        e0_cyc = cyc + 1;
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop;
        #(bit_t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int f0;
        int n;
        logic [7:0] a5;

        rx    = 1'b1;
        reset = 1'b1;
        wait_cycles(3);
        check_eq("rst_char_data", char_data, 0);
        check_eq("rst_char_ready", char_ready, 0);
        check_eq("rst_framing_error", framing_error, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b0;
        wait_cycles(5);

        // Single character with latency measurement.
        got_q.delete();
        r0 = ready_cnt;
        f0 = fe_cnt;
        send_frame(8'h53, 1'b1, BIT_T);
        wait_cycles(4);
        check_eq("t1_ready_count", ready_cnt - r0, 1);
        expect_byte("t1_byte", 8'h53);
        check_eq("t1_latency", ready_cyc - e0_cyc, 154);
        check_eq("t1_no_fe", fe_cnt - f0, 0);

        // "S3\r\n" with no idle between frames.
        got_q.delete();
        r0 = ready_cnt;
        f0 = fe_cnt;
        send_frame(8'h53, 1'b1, BIT_T);
        send_frame(8'h33, 1'b1, BIT_T);
        send_frame(8'h0D, 1'b1, BIT_T);
        send_frame(8'h0A, 1'b1, BIT_T);
        wait_cycles(4);
        check_eq("t2_ready_count", ready_cnt - r0, 4);
        expect_byte("t2_byte0", 8'h53);
        expect_byte("t2_byte1", 8'h33);
        expect_byte("t2_byte2", 8'h0D);
        expect_byte("t2_byte3", 8'h0A);
        check_eq("t2_no_fe", fe_cnt - f0, 0);

        // Four-clock glitch on the line.
        r0 = ready_cnt;
        f0 = fe_cnt;
        rx = 1'b0;
        wait_cycles(3);
        check_eq("t3_busy_rise", busy, 1);
        wait_cycles(1);
        rx = 1'b1;
        n = 0;
        while (busy && n < 11) begin
            wait_cycles(1);
            n++;
        end
        check_eq("t3_busy_fall", busy, 0);
        wait_cycles(20);
        check_eq("t3_no_ready", ready_cnt - r0, 0);
        check_eq("t3_no_fe", fe_cnt - f0, 0);

        // Break: 0x00 with stop low, line held low for three more bit times.
        got_q.delete();
        r0 = ready_cnt;
        f0 = fe_cnt;
        send_frame(8'h00, 1'b0, BIT_T);
        wait_cycles(48);
        check_eq("t4_fe_count", fe_cnt - f0, 1);
        check_eq("t4_no_ready", ready_cnt - r0, 0);
        check_eq("t4_busy_in_break", busy, 1);
        check_eq("t4_data_held", char_data, 8'h0A);
        rx = 1'b1;
        wait_cycles(5);
        check_eq("t4_busy_after_break", busy, 0);
        send_frame(8'h41, 1'b1, BIT_T);
        wait_cycles(4);
        expect_byte("t4_byte", 8'h41);
        check_eq("t4_char_data", char_data, 8'h41);
        check_eq("t4_fe_total", fe_cnt - f0, 1);

        // Reset during data bit 3 of 0xA5.
        got_q.delete();
        r0 = ready_cnt;
        a5 = 8'hA5;
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rx = a5[i];
            if (i < 3) #(BIT_T);
        end
        wait_cycles(4);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_char_data", char_data, 0);
        check_eq("t5_rst_char_ready", char_ready, 0);
        check_eq("t5_rst_framing_error", framing_error, 0);
        check_eq("t5_rst_busy", busy, 0);
        rx = 1'b1;
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(5);
        check_eq("t5_idle_after_reset", busy, 0);
        check_eq("t5_no_partial_byte", ready_cnt - r0, 0);
        send_frame(8'hA5, 1'b1, BIT_T);
        wait_cycles(4);
        expect_byte("t5_byte", 8'hA5);
        check_eq("t5_char_data", char_data, 8'hA5);

        // Sender running fast and slow (15.5 and 16.5 clocks per bit).
        got_q.delete();
        r0 = ready_cnt;
        f0 = fe_cnt;
        send_frame(8'h55, 1'b1, 155);
        wait_cycles(20);
        send_frame(8'h55, 1'b1, 165);
        wait_cycles(20);
        check_eq("t6_ready_count", ready_cnt - r0, 2);
        expect_byte("t6_fast_byte", 8'h55);
        expect_byte("t6_slow_byte", 8'h55);
        check_eq("t6_no_fe", fe_cnt - f0, 0);

        check_eq("pulse_overlap", overlap_cnt, 0);
        check_eq("pulse_width", long_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
